// File: rtl/core_sequencer.sv
// Fetch/sequencing unit: owns the PC and start/done handshake, stalls
// data-memory instructions and gates retirement for the accumulator core.
module core_sequencer #(
    parameter int PC_WIDTH    = 11,
    parameter int START_PC    = 0,
    parameter int MEM_LATENCY = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 mem_req,
    input  logic                 branch_en,
    input  logic                 branch_rel,
    input  logic [PC_WIDTH-1:0]  branch_target,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 exec_en,
    output logic                 stall,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retired_count
);

    localparam int WCW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [PC_WIDTH-1:0] START     = PC_WIDTH'(START_PC);
    localparam logic [WCW-1:0]      WAIT_INIT = (MEM_LATENCY > 0) ? WCW'(MEM_LATENCY - 1) : '0;
    localparam bit                  HAS_WAIT  = (MEM_LATENCY > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state, state_next;
    logic [WCW-1:0]     wait_cnt;
    logic [PC_WIDTH-1:0] pc_next;
    logic               arm, run_cycle, enter_wait, go_done;

    // Relative branches wrap naturally: unsigned add of the same width is the
    // two's-complement sum modulo 2^PC_WIDTH.
    always_comb begin
        if (!branch_en)      pc_next = pc + PC_WIDTH'(1);
        else if (branch_rel) pc_next = pc + branch_target;
        else                 pc_next = branch_target;
    end

    always_comb begin
        state_next = state;
        exec_en    = 1'b0;
        stall      = (state == S_WAIT);
        arm        = 1'b0;
        run_cycle  = 1'b0;
        enter_wait = 1'b0;
        go_done    = 1'b0;
        if (start) begin
            state_next = S_ARM;
            arm        = 1'b1;
        end else begin
            case (state)
                S_ARM: begin
                    arm        = 1'b1;
                    state_next = S_RUN;
                end
                S_RUN: begin
                    run_cycle = 1'b1;
                    if (halt) begin
                        go_done    = 1'b1;
                        state_next = S_DONE;
                    end else if (mem_req && HAS_WAIT) begin
                        enter_wait = 1'b1;
                        state_next = S_WAIT;
                    end else begin
                        exec_en = 1'b1;
                    end
                end
                S_WAIT: begin
                    run_cycle = 1'b1;
                    if (wait_cnt == '0) begin
                        exec_en    = 1'b1;
                        state_next = S_RUN;
                    end
                end
                S_IDLE, S_DONE: state_next = state;
                default:        state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            pc            <= START;
            done          <= 1'b0;
            wait_cnt      <= '0;
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            state <= state_next;
            if (arm) begin
                pc            <= START;
                done          <= 1'b0;
                cycle_count   <= '0;
                retired_count <= '0;
            end else begin
                if (exec_en) begin
                    pc <= pc_next;
                    if (retired_count != '1) retired_count <= retired_count + CNT_WIDTH'(1);
                end
                if (run_cycle && cycle_count != '1) cycle_count <= cycle_count + CNT_WIDTH'(1);
                if (go_done) done <= 1'b1;
                if (enter_wait)
                    wait_cnt <= WAIT_INIT;
                else if (state == S_WAIT && wait_cnt != '0)
                    wait_cnt <= wait_cnt - WCW'(1);
            end
        end
    end

endmodule
